// File: rtl/dmem_arbiter.sv
// Shares the single-port DataRAM between the MEM stage and a debug/loader port.
// CPU has priority; a starvation counter forces a pending debug request through.
module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Cpu_Req,
    input  logic        Cpu_We,
    input  logic [31:0] Cpu_Addr,
    input  logic [31:0] Cpu_Din,
    output logic [31:0] Cpu_Dout,
    output logic        Cpu_Stall,
    input  logic        Dbg_Req,
    input  logic        Dbg_We,
    input  logic [31:0] Dbg_Addr,
    input  logic [31:0] Dbg_Din,
    output logic        Dbg_Ack,
    output logic [31:0] Dbg_Dout,
    output logic        Mem_WE,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_DataIn,
    input  logic [31:0] Mem_DataOut
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dbg_ack_q;
    logic [31:0] dbg_dout_q;
    logic        arb_state;
    logic        dbg_grant;

    assign arb_state = (state_q == IDLE) || (state_q == WAIT);
    assign dbg_grant = !Reset && Dbg_Req && arb_state && (!Cpu_Req || (cnt_q == STARVE_LIM));

    always_comb begin
        state_d = IDLE;
        if (dbg_grant) begin
            state_d = ACK;
        end else begin
            unique case (state_q)
                IDLE:    state_d = Dbg_Req ? WAIT : IDLE;
                WAIT:    state_d = Dbg_Req ? WAIT : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Reaching this increment implies the CPU won the cycle, since debug was not granted.
    always_comb begin
        cnt_d = cnt_q;
        if (dbg_grant || !Dbg_Req || !arb_state) begin
            cnt_d = '0;
        end else if (cnt_q != STARVE_LIM) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dbg_ack_q  <= 1'b0;
            dbg_dout_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dbg_ack_q <= dbg_grant;
            if (dbg_grant) begin
                dbg_dout_q <= Mem_DataOut;
            end
        end
    end

    always_comb begin
        if (dbg_grant) begin
            Mem_Addr   = Dbg_Addr;
            Mem_DataIn = Dbg_Din;
            Mem_WE     = Dbg_We;
        end else begin
            Mem_Addr   = Cpu_Addr;
            Mem_DataIn = Cpu_Din;
            Mem_WE     = Cpu_Req && Cpu_We && !Reset;
        end
    end

    assign Cpu_Stall = Cpu_Req && dbg_grant;
    assign Cpu_Dout  = Mem_DataOut;
    assign Dbg_Ack   = dbg_ack_q;
    assign Dbg_Dout  = dbg_dout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural DataRAM (async read, negedge write) and a
// scoreboard of expected debug read data popped on every Dbg_Ack.
module tb_dmem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Cpu_Req, Cpu_We;
    logic [31:0] Cpu_Addr, Cpu_Din, Cpu_Dout;
    logic        Cpu_Stall;
    logic        Dbg_Req, Dbg_We;
    logic [31:0] Dbg_Addr, Dbg_Din, Dbg_Dout;
    logic        Dbg_Ack;
    logic        Mem_WE;
    logic [31:0] Mem_Addr, Mem_DataIn, Mem_DataOut;

    always #5 Clk = ~Clk;

    dmem_arbiter #(.STARVE_MAX(2)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Cpu_Req     (Cpu_Req),
        .Cpu_We      (Cpu_We),
        .Cpu_Addr    (Cpu_Addr),
        .Cpu_Din     (Cpu_Din),
        .Cpu_Dout    (Cpu_Dout),
        .Cpu_Stall   (Cpu_Stall),
        .Dbg_Req     (Dbg_Req),
        .Dbg_We      (Dbg_We),
        .Dbg_Addr    (Dbg_Addr),
        .Dbg_Din     (Dbg_Din),
        .Dbg_Ack     (Dbg_Ack),
        .Dbg_Dout    (Dbg_Dout),
        .Mem_WE      (Mem_WE),
        .Mem_Addr    (Mem_Addr),
        .Mem_DataIn  (Mem_DataIn),
        .Mem_DataOut (Mem_DataOut)
    );

    logic [31:0] ram [0:63];
    assign Mem_DataOut = ram[Mem_Addr[7:2]];
    always @(negedge Clk) if (Mem_WE) ram[Mem_Addr[7:2]] <= Mem_DataIn;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] dbg_exp [$];
    logic [31:0] exp_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic cpu(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] din);
        Cpu_Req = req; Cpu_We = we; Cpu_Addr = addr; Cpu_Din = din;
    endtask

    task automatic dbg(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] din);
        Dbg_Req = req; Dbg_We = we; Dbg_Addr = addr; Dbg_Din = din;
    endtask

    // Every Ack must match the oldest outstanding debug access.
    always @(posedge Clk) begin
        #2;
        if (Dbg_Ack === 1'b1) begin
            if (dbg_exp.size() == 0) begin
                check("dbg_ack_spurious", 32'(Dbg_Ack), 32'd0);
            end else begin
                exp_word = dbg_exp.pop_front();
                check("dbg_dout", Dbg_Dout, exp_word);
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = '0;

        // Reset with both requesters active: nothing may reach memory.
        Reset = 1'b1;
        cpu(1, 1, 32'h10, 32'h5555_5555);
        dbg(1, 1, 32'h10, 32'h6666_6666);
        cyc(); #2;
        check("rst_we", 32'(Mem_WE), 0);
        check("rst_stall", 32'(Cpu_Stall), 0);
        cyc(); #2;
        check("rst_ack", 32'(Dbg_Ack), 0);
        check("rst_dout", Dbg_Dout, 0);
        check("rst_we2", 32'(Mem_WE), 0);
        cpu(0, 0, 0, 0);
        dbg(0, 0, 0, 0);
        cyc();
        Reset = 1'b0;

        // CPU only: store then load.
        cpu(1, 1, 32'h10, 32'hDEAD_BEEF); #2;
        check("s1_stall", 32'(Cpu_Stall), 0);
        check("s1_we", 32'(Mem_WE), 1);
        check("s1_addr", Mem_Addr, 32'h10);
        cyc();
        cpu(1, 0, 32'h10, 0); #2;
        check("s1_dout", Cpu_Dout, 32'hDEAD_BEEF);
        check("s1_stall2", 32'(Cpu_Stall), 0);

        // Debug read with CPU idle; Req kept high in the Ack cycle must not regrant.
        cyc();
        cpu(0, 0, 32'h30, 0);
        dbg(1, 0, 32'h10, 0);
        dbg_exp.push_back(32'hDEAD_BEEF); #2;
        check("s2_addr", Mem_Addr, 32'h10);
        check("s2_we", 32'(Mem_WE), 0);
        cyc(); #2;
        check("s2_ack", 32'(Dbg_Ack), 1);
        check("s2_no_grant_in_ack", Mem_Addr, 32'h30);
        cyc();
        dbg(0, 0, 0, 0); #2;
        check("s2_ack_drop", 32'(Dbg_Ack), 0);

        // Starvation: CPU wins two cycles, debug forced on the third.
        cyc();
        cpu(1, 0, 32'h14, 0);
        dbg(1, 0, 32'h10, 0); #2;
        check("s3_c0_stall", 32'(Cpu_Stall), 0);
        check("s3_c0_addr", Mem_Addr, 32'h14);
        cyc(); #2;
        check("s3_c1_stall", 32'(Cpu_Stall), 0);
        cyc();
        dbg_exp.push_back(32'hDEAD_BEEF); #2;
        check("s3_c2_stall", 32'(Cpu_Stall), 1);
        check("s3_c2_addr", Mem_Addr, 32'h10);
        cyc();
        dbg(0, 0, 0, 0); #2;
        check("s3_c3_ack", 32'(Dbg_Ack), 1);
        check("s3_c3_stall", 32'(Cpu_Stall), 0);
        check("s3_c3_addr", Mem_Addr, 32'h14);

        // Debug write lands while a CPU store to the same word is stalled.
        cyc();
        cpu(1, 1, 32'h24, 32'h1111_1111);
        dbg(1, 1, 32'h20, 32'h1234_5678); #2;
        check("s4_c0_stall", 32'(Cpu_Stall), 0);
        check("s4_c0_din", Mem_DataIn, 32'h1111_1111);
        cyc(); #2;
        check("s4_c1_stall", 32'(Cpu_Stall), 0);
        cyc();
        cpu(1, 1, 32'h20, 32'hAAAA_0000);
        dbg_exp.push_back(32'h1234_5678); #2;
        check("s4_stall", 32'(Cpu_Stall), 1);
        check("s4_dbg_din", Mem_DataIn, 32'h1234_5678);
        check("s4_dbg_we", 32'(Mem_WE), 1);
        cyc();
        dbg(0, 0, 0, 0); #2;
        check("s4_ack", 32'(Dbg_Ack), 1);
        check("s4_cpu_stall", 32'(Cpu_Stall), 0);
        check("s4_cpu_din", Mem_DataIn, 32'hAAAA_0000);
        check("s4_cpu_we", 32'(Mem_WE), 1);
        cyc();
        cpu(1, 0, 32'h20, 0); #2;
        check("s4_final", Cpu_Dout, 32'hAAAA_0000);
        cyc();
        cpu(1, 0, 32'h24, 0); #2;
        check("s4_other", Cpu_Dout, 32'h1111_1111);

        // Abandoned request: no Ack, and the counter starts over on the next request.
        cyc();
        cpu(1, 0, 32'h14, 0);
        dbg(1, 0, 32'h10, 0); #2;
        check("s5_denied", 32'(Cpu_Stall), 0);
        cyc();
        dbg(0, 0, 0, 0); #2;
        check("s5_noack", 32'(Dbg_Ack), 0);
        cyc(); #2;
        check("s5_noack2", 32'(Dbg_Ack), 0);
        cyc();
        dbg(1, 0, 32'h10, 0); #2;
        check("s5_r0_stall", 32'(Cpu_Stall), 0);
        cyc(); #2;
        check("s5_r1_stall", 32'(Cpu_Stall), 0);
        cyc();
        dbg_exp.push_back(32'hDEAD_BEEF); #2;
        check("s5_r2_stall", 32'(Cpu_Stall), 1);
        cyc();
        dbg(0, 0, 0, 0); #2;
        check("s5_ack", 32'(Dbg_Ack), 1);

        // Reset in the cycle after a debug grant.
        cyc();
        cpu(0, 0, 32'h14, 0);
        dbg(1, 1, 32'h30, 32'hCAFE_F00D);
        dbg_exp.push_back(32'hCAFE_F00D); #2;
        check("s6_grant_we", 32'(Mem_WE), 1);
        cyc();
        Reset = 1'b1;
        cpu(1, 1, 32'h34, 32'h9999_9999);
        dbg(0, 0, 0, 0); #2;
        check("s6_ack", 32'(Dbg_Ack), 1);
        check("s6_we", 32'(Mem_WE), 0);
        check("s6_stall", 32'(Cpu_Stall), 0);
        cyc(); #2;
        check("s6_ack_after", 32'(Dbg_Ack), 0);
        check("s6_dout", Dbg_Dout, 0);
        check("s6_we2", 32'(Mem_WE), 0);
        check("s6_stall2", 32'(Cpu_Stall), 0);

        // Reset while waiting, in the cycle debug would otherwise be granted.
        cyc();
        Reset = 1'b0;
        cpu(1, 0, 32'h14, 0);
        dbg(1, 1, 32'h38, 32'h7777_7777); #2;
        check("s7_wait_stall", 32'(Cpu_Stall), 0);
        cyc();
        Reset = 1'b1;
        cpu(0, 0, 32'h14, 0); #2;
        check("s7_rst_we", 32'(Mem_WE), 0);
        check("s7_rst_stall", 32'(Cpu_Stall), 0);
        cyc();
        Reset = 1'b0;
        dbg(0, 0, 0, 0);
        cpu(1, 0, 32'h38, 0); #2;
        check("s7_noack", 32'(Dbg_Ack), 0);
        check("s7_nowrite", Cpu_Dout, 0);
        cyc(); #2;
        check("s7_noack2", 32'(Dbg_Ack), 0);

        cyc();
        cpu(0, 0, 0, 0);
        #5;
        check("sb_empty", 32'(dbg_exp.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
